vp_update_scheduler: RTL
========================

// Module: vp_update_scheduler
// PURPOSE
//  Sequences all writes into the value-predictor value/confidence tables.
//  Buffers validation feedback in a small FIFO, merges same-index pairs, and emits a confidence op per write port.
//  After reset or flush, sweeps every table index to zero (table RAMs have no reset).
//  Sits between the commit/feedback interface and the table write ports (wra/wrb).
// PARAMETERS
//  P_STORAGE_SIZE  2048  table entries, power of 2; P_INDEX_WIDTH = $clog2(P_STORAGE_SIZE)
//  P_NUM_PRED      2     feedback lanes = table write ports; only 1 or 2 supported
//  P_FIFO_DEPTH    8     feedback FIFO entries, power of 2, >= 2*P_NUM_PRED
// PORTS
//  clk_i            in   1                     main clock
//  rst_ni           in   1                     reset, asynchronous, active-low
//  flush_i          in   1                     clear FIFO and re-sweep tables
//  fb_pc_i          in   [P_NUM_PRED][31:1]    feedback PC; index = pc[P_INDEX_WIDTH:1]
//  fb_actual_i      in   [P_NUM_PRED][32]      executed result
//  fb_mispredict_i  in   [P_NUM_PRED]          prediction was wrong
//  fb_conf_i        in   [P_NUM_PRED]          confidence was saturated
//  fb_valid_i       in   [P_NUM_PRED]          per-lane valid
//  fb_ready_o       out  1                     all lanes accepted this cycle
//  wr_index_o       out  [P_NUM_PRED][P_INDEX_WIDTH]  table write index
//  wr_value_o       out  [P_NUM_PRED][32]      value to write
//  wr_conf_op_o     out  [P_NUM_PRED][2]       conf_op_e for the confidence datapath
//  wr_valid_o       out  [P_NUM_PRED]          write strobe
//  wr_ready_i       in   1                     table ports accept writes this cycle
//  init_done_o      out  1                     tables initialised; predictions usable
// BEHAVIOUR
//  FSM states:
//   - INIT (entered on reset and on flush_i).
//   - RUN (entered from INIT when the last sweep group is accepted).
//  INIT:
//   - Counter starts at 0. Lane k writes index cnt+k, value 0, op RESET.
//   - Counter advances by P_NUM_PRED only when wr_ready_i=1.
//   - Takes P_STORAGE_SIZE/P_NUM_PRED accepted cycles.
//   - fb_ready_o=0 and init_done_o=0 throughout.
//  RUN:
//   - fb_ready_o = (free slots >= P_NUM_PRED) && !flush_i. Registered from the count; no combinational path from fb_*.
//  Enqueue (fb_ready_o && any fb_valid_i):
//   - Valid lanes are compacted in lane order; lane 0 is older.
//   - Per-entry op: mispredict -> RESET; else conf -> HOLD; else INCR.
//  Dequeue:
//   - wr lane k shows FIFO entry head+k if count > k. wr_* are driven from FIFO registers.
//   - An update accepted in cycle N is writable in N+1.
//   - On wr_ready_i=1, pop min(count, P_NUM_PRED). When wr_ready_i=0, wr_* are held stable.
//  Merge (P_NUM_PRED=2, both wr lanes valid, equal index):
//   - wr_valid_o=2'b10; lane 1 value is the newer entry's.
//   - op = ADD2 if neither mispredicted, else RESET. Both entries pop.
//   - Downstream saturates ADD2/INCR.
//  Simultaneous push and pop in the same cycle is allowed; count = count + pushed - popped.
//  Pointers wrap modulo P_FIFO_DEPTH. A full FIFO deasserts ready; nothing is dropped.
//  flush_i:
//   - Has priority over everything.
//   - Next cycle: FIFO empty, state INIT, counter 0, init_done_o=0.
//   - Flush during INIT restarts the sweep from 0.
//  Reset values: state INIT, counter 0, FIFO empty, fb_ready_o=0, wr_valid_o=0, init_done_o=0.
//  Reset mid-operation drops all queued updates.
// CONFIGURATION
//  `VP_SCHED_PERF_EN defined:
//   - Adds outputs perf_merge_o[31:0] (merged pairs) and perf_stall_o[31:0] (cycles with fb_valid_i!=0 && !fb_ready_o).
//   - Counters saturate at 32'hFFFF_FFFF and clear on reset only.
//  Undefined: ports and logic are absent; all other behaviour is identical.
// STRUCTURE
//  vp_pkg:
//   - conf_op_e {CONF_HOLD=0, CONF_INCR=1, CONF_ADD2=2, CONF_RESET=3}, CONF_OP_W=2.
//   - sched_state_e {ST_INIT, ST_RUN}.
//  Sub-module vp_upd_fifo:
//   - Multi-push/multi-pop circular buffer.
//   - Parameterised on entry width, depth and lane count.
//   - Exposes count and head..head+P_NUM_PRED-1.
//  Top level holds the FSM, init counter, op encoding, merge logic and perf counters.
// TESTING
//  1. Release rst_ni, wr_ready_i=1 (defaults)
//     -> 1024 cycles of writes {0,1},{2,3}..{2046,2047}, op RESET;
//     -> then init_done_o=1, fb_ready_o=1.
//  2. RUN, lane 0 only: pc idx 5, actual 32'hDEAD_BEEF, mispredict=0, conf=0
//     -> next cycle wr_valid_o=2'b01, index 5, op INCR.
//  3. Both lanes idx 7, actuals 1 and 2, no mispredict
//     -> wr_valid_o=2'b10, value 2, op ADD2.
//     Repeat with lane 0 mispredict -> op RESET.
//  4. wr_ready_i=0, push 2 updates/cycle for 4 cycles
//     -> count 8, fb_ready_o=0, wr_* stable;
//     -> wr_ready_i=1 drains in 4 cycles, in order, with wrap.
//  5. 3 entries queued, pulse flush_i
//     -> no stale write; next cycle INIT writes idx {0,1}, init_done_o=0.
//  6. Deassert rst_ni mid-sweep at cnt=600
//     -> outputs reset immediately; sweep restarts at 0.
//     With VP_SCHED_PERF_EN, test 3 gives perf_merge_o=2.

Source files
------------

// File: rtl/vp_update_scheduler_pkg.sv
// Shared types for the value-predictor update scheduler: confidence ops and FSM states.
package vp_pkg;

  localparam int unsigned CONF_OP_W = 2;

  typedef enum logic [CONF_OP_W-1:0] {
    CONF_HOLD  = 2'd0,
    CONF_INCR  = 2'd1,
    CONF_ADD2  = 2'd2,
    CONF_RESET = 2'd3
  } conf_op_e;

  typedef enum logic {ST_INIT, ST_RUN} sched_state_e;

  function automatic conf_op_e conf_op_f(input logic mispredict, input logic conf);
    if (mispredict) return CONF_RESET;
    if (conf)       return CONF_HOLD;
    return CONF_INCR;
  endfunction

endpackage

// File: rtl/vp_update_scheduler_if.sv
// Feedback-in / table-write-out bundle of the update scheduler.
interface vp_update_scheduler_if #(
  parameter int unsigned P_NUM_PRED    = 2,
  parameter int unsigned P_INDEX_WIDTH = 11
);
  import vp_pkg::*;

  logic [31:1]              fb_pc_i       [P_NUM_PRED];
  logic [31:0]              fb_actual_i   [P_NUM_PRED];
  logic [P_NUM_PRED-1:0]    fb_mispredict_i;
  logic [P_NUM_PRED-1:0]    fb_conf_i;
  logic [P_NUM_PRED-1:0]    fb_valid_i;
  logic                     fb_ready_o;
  logic [P_INDEX_WIDTH-1:0] wr_index_o    [P_NUM_PRED];
  logic [31:0]              wr_value_o    [P_NUM_PRED];
  logic [CONF_OP_W-1:0]     wr_conf_op_o  [P_NUM_PRED];
  logic [P_NUM_PRED-1:0]    wr_valid_o;
  logic                     wr_ready_i;
  logic                     init_done_o;

  modport slave (
    input  fb_pc_i, fb_actual_i, fb_mispredict_i, fb_conf_i, fb_valid_i, wr_ready_i,
    output fb_ready_o, wr_index_o, wr_value_o, wr_conf_op_o, wr_valid_o, init_done_o
  );

  modport master (
    output fb_pc_i, fb_actual_i, fb_mispredict_i, fb_conf_i, fb_valid_i, wr_ready_i,
    input  fb_ready_o, wr_index_o, wr_value_o, wr_conf_op_o, wr_valid_o, init_done_o
  );

endinterface

// File: rtl/vp_update_scheduler_fifo.sv
// Circular buffer with up to P_LANES pushes and pops per cycle; exposes the head window.
module vp_upd_fifo #(
  parameter  int unsigned P_ENTRY_W = 45,
  parameter  int unsigned P_DEPTH   = 8,
  parameter  int unsigned P_LANES   = 2,
  localparam int unsigned PTR_W     = $clog2(P_DEPTH),
  localparam int unsigned CNT_W     = PTR_W + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [CNT_W-1:0]     push_cnt_i,
  input  logic [P_ENTRY_W-1:0] push_data_i [P_LANES],
  input  logic [CNT_W-1:0]     pop_cnt_i,
  output logic [CNT_W-1:0]     count_o,
  output logic [P_ENTRY_W-1:0] head_data_o [P_LANES]
);

  logic [P_ENTRY_W-1:0] mem_q [P_DEPTH];
  logic [P_ENTRY_W-1:0] mem_d [P_DEPTH];
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;

  always_comb begin
    mem_d = mem_q;
    for (int unsigned k = 0; k < P_LANES; k++) begin
      if (CNT_W'(k) < push_cnt_i) mem_d[tail_q + PTR_W'(k)] = push_data_i[k];
    end
    head_d  = head_q + PTR_W'(pop_cnt_i);
    tail_d  = tail_q + PTR_W'(push_cnt_i);
    count_d = count_q + push_cnt_i - pop_cnt_i;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < P_LANES; k++) head_data_o[k] = mem_q[head_q + PTR_W'(k)];
  end

  assign count_o = count_q;

  always_ff @(posedge clk_i) mem_q <= mem_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vp_update_scheduler.sv
// Value-predictor table write sequencer: init sweep, feedback FIFO, same-index merge.
// Optional perf counters under `VP_SCHED_PERF_EN.
module vp_update_scheduler
  import vp_pkg::*;
#(
  parameter int unsigned P_STORAGE_SIZE = 2048,
  parameter int unsigned P_NUM_PRED     = 2,
  parameter int unsigned P_FIFO_DEPTH   = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  vp_update_scheduler_if.slave bus
`ifdef VP_SCHED_PERF_EN
  ,
  output logic [31:0] perf_merge_o,
  output logic [31:0] perf_stall_o
`endif
);

  localparam int unsigned IDX_W = $clog2(P_STORAGE_SIZE);
  localparam int unsigned CNT_W = $clog2(P_FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_GRP = IDX_W'(P_STORAGE_SIZE - P_NUM_PRED);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [31:0]      value;
    conf_op_e         op;
  } upd_t;
  localparam int unsigned ENTRY_W = $bits(upd_t);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             init_wr_q;
  logic             fb_ready_q, fb_ready_d;
  logic             init_done_q, init_done_d;
  logic             fb_ready;
  logic             merge;

  logic [ENTRY_W-1:0] push_data [P_NUM_PRED];
  logic [ENTRY_W-1:0] head_data [P_NUM_PRED];
  upd_t               head      [P_NUM_PRED];
  logic [CNT_W-1:0]   push_cnt, pop_cnt, fifo_cnt, fifo_cnt_nxt;

  assign fb_ready        = fb_ready_q && !flush_i;
  assign bus.fb_ready_o  = fb_ready;
  assign bus.init_done_o = init_done_q;

  vp_upd_fifo #(
    .P_ENTRY_W (ENTRY_W),
    .P_DEPTH   (P_FIFO_DEPTH),
    .P_LANES   (P_NUM_PRED)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .push_cnt_i  (push_cnt),
    .push_data_i (push_data),
    .pop_cnt_i   (pop_cnt),
    .count_o     (fifo_cnt),
    .head_data_o (head_data)
  );

  // Valid lanes are packed into consecutive FIFO slots, lane 0 first.
  always_comb begin
    upd_t lane_upd;
    lane_upd = '0;
    push_cnt = '0;
    for (int unsigned j = 0; j < P_NUM_PRED; j++) push_data[j] = '0;
    if (fb_ready) begin
      for (int unsigned k = 0; k < P_NUM_PRED; k++) begin
        if (bus.fb_valid_i[k]) begin
          lane_upd.idx   = bus.fb_pc_i[k][IDX_W:1];
          lane_upd.value = bus.fb_actual_i[k];
          lane_upd.op    = conf_op_f(bus.fb_mispredict_i[k], bus.fb_conf_i[k]);
          for (int unsigned j = 0; j < P_NUM_PRED; j++) begin
            if (CNT_W'(j) == push_cnt) push_data[j] = lane_upd;
          end
          push_cnt = push_cnt + 1'b1;
        end
      end
    end
  end

  // Head window drives the write ports; a same-index pair collapses onto the last lane.
  always_comb begin
    for (int unsigned k = 0; k < P_NUM_PRED; k++) head[k] = upd_t'(head_data[k]);
    merge = (P_NUM_PRED == 2) && (fifo_cnt >= CNT_W'(2)) &&
            (head[0].idx == head[P_NUM_PRED-1].idx);
    for (int unsigned k = 0; k < P_NUM_PRED; k++) begin
      bus.wr_index_o[k]   = head[k].idx;
      bus.wr_value_o[k]   = head[k].value;
      bus.wr_conf_op_o[k] = head[k].op;
      bus.wr_valid_o[k]   = fifo_cnt > CNT_W'(k);
    end
    if (merge) begin
      bus.wr_valid_o                 = '0;
      bus.wr_valid_o[P_NUM_PRED-1]   = 1'b1;
      bus.wr_conf_op_o[P_NUM_PRED-1] = (head[0].op != CONF_RESET &&
                                        head[P_NUM_PRED-1].op != CONF_RESET) ? CONF_ADD2 : CONF_RESET;
    end
    if (state_q == ST_INIT) begin
      for (int unsigned k = 0; k < P_NUM_PRED; k++) begin
        bus.wr_index_o[k]   = cnt_q + IDX_W'(k);
        bus.wr_value_o[k]   = '0;
        bus.wr_conf_op_o[k] = CONF_RESET;
      end
      bus.wr_valid_o = {P_NUM_PRED{init_wr_q}};
    end
    if (flush_i) bus.wr_valid_o = '0;
    pop_cnt = '0;
    if (state_q == ST_RUN && bus.wr_ready_i && !flush_i)
      pop_cnt = (fifo_cnt < CNT_W'(P_NUM_PRED)) ? fifo_cnt : CNT_W'(P_NUM_PRED);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT && init_wr_q && bus.wr_ready_i) begin
      cnt_d = cnt_q + IDX_W'(P_NUM_PRED);
      if (cnt_q == LAST_GRP) state_d = ST_RUN;
    end
    if (flush_i) begin
      state_d = ST_INIT;
      cnt_d   = '0;
    end
    fifo_cnt_nxt = flush_i ? '0 : fifo_cnt + push_cnt - pop_cnt;
    fb_ready_d   = (state_d == ST_RUN) &&
                   ((CNT_W'(P_FIFO_DEPTH) - fifo_cnt_nxt) >= CNT_W'(P_NUM_PRED));
    init_done_d  = (state_d == ST_RUN);
  end

  // init_wr_q keeps the sweep strobe low while reset is held and for the first edge after.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_wr_q   <= 1'b0;
      fb_ready_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_wr_q   <= 1'b1;
      fb_ready_q  <= fb_ready_d;
      init_done_q <= init_done_d;
    end
  end

`ifdef VP_SCHED_PERF_EN
  logic [31:0] perf_merge_q, perf_merge_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_merge_d = perf_merge_q;
    perf_stall_d = perf_stall_q;
    if (merge && pop_cnt != '0 && perf_merge_q != '1) perf_merge_d = perf_merge_q + 32'd1;
    if (|bus.fb_valid_i && !fb_ready && perf_stall_q != '1) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_merge_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_merge_q <= perf_merge_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_merge_o = perf_merge_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule
